fifo_buffer: RTL

FIFO_BUFFER -- requirements
Module: fifo_buffer

---
 rtl/fifo_buffer_pkg.sv | 15 +
 rtl/fifo_ptr_ctrl.sv | 68 ++++++
 rtl/fifo_buffer.sv | 69 ++++++
 3 files changed

// File: rtl/fifo_buffer_pkg.sv
// rtl/fifo_buffer_pkg.sv - shared defaults and width helper for the fifo buffer
package fifo_buffer_pkg;

   localparam int FIFO_DEF_DATA_W = 8;
   localparam int FIFO_DEF_DEPTH  = 16;

   // Smallest r with 2**r >= value; DEPTH is a power of two, so this is exact.
   function automatic int fifo_log2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - pointers, occupancy, status flags and sticky errors for fifo_buffer
module fifo_ptr_ctrl import fifo_buffer_pkg::*; #(
   parameter int DEPTH     = FIFO_DEF_DEPTH,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2,
   localparam int AW       = fifo_log2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic          rd_en,
   output logic          wr_acc,
   output logic          rd_acc,
   output logic [AW-1:0] wr_ptr,
   output logic [AW-1:0] rd_ptr,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty,
   output logic          overflow,
   output logic          underflow
);

   localparam int        CW        = AW + 1;
   localparam logic [AW:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [AW:0] AFULL_C  = CW'(AFULL_TH);
   localparam logic [AW:0] AEMPTY_C = CW'(AEMPTY_TH);

   logic [AW:0] count_nxt;

   // A write into a full FIFO is fine when a read frees a slot on the same edge.
   assign rd_acc = rd_en && !empty;
   assign wr_acc = wr_en && (!full || rd_en);

   always_comb begin
      count_nxt = count;
      if (wr_acc && !rd_acc)
         count_nxt = count + 1'b1;
      else if (rd_acc && !wr_acc)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         count        <= count_nxt;
         full         <= (count_nxt == DEPTH_C);
         empty        <= (count_nxt == '0);
         almost_full  <= (count_nxt >= AFULL_C);
         almost_empty <= (count_nxt <= AEMPTY_C);
         if (wr_en && full && !rd_en) overflow  <= 1'b1;
         if (rd_en && empty)          underflow <= 1'b1;
      end
   end

endmodule

// File: rtl/fifo_buffer.sv
// rtl/fifo_buffer.sv - single-clock synchronous FIFO with registered read port
module fifo_buffer import fifo_buffer_pkg::*; #(
   parameter int DATA_W    = FIFO_DEF_DATA_W,
   parameter int DEPTH     = FIFO_DEF_DEPTH,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2,
   localparam int AW       = fifo_log2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [AW:0]       count,
   output logic              overflow,
   output logic              underflow
);

   logic              wr_acc;
   logic              rd_acc;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [DATA_W-1:0] mem [DEPTH];

   fifo_ptr_ctrl #(
      .DEPTH     (DEPTH),
      .AFULL_TH  (AFULL_TH),
      .AEMPTY_TH (AEMPTY_TH)
   ) u_ptr_ctrl (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
      .wr_acc       (wr_acc),
      .rd_acc       (rd_acc),
      .wr_ptr       (wr_ptr),
      .rd_ptr       (rd_ptr),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // Storage is deliberately not reset; empty gates every read of a stale slot.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wr_data;
   end

   // On a full read+write both pointers match; the read still sees the old word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) rd_data <= mem[rd_ptr];
      end
   end

endmodule
